// File: rtl/zxuno_pkg.sv
// Shared constants and FSM state encoding for the ZX-UNO register bus.
package zxuno_pkg;

    // Full 16-bit I/O addresses of the register-select and register-data ports.
    localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
    localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

    // Register numbers decoded downstream of this block.
    localparam logic [7:0] REG_MASTERCONF   = 8'h00;
    localparam logic [7:0] REG_MASTERMAPPER = 8'h01;
    localparam logic [7:0] REG_SCANDBLCTRL  = 8'h0B;
    localparam logic [7:0] REG_COREID       = 8'hFF;

    // Register-port decoder FSM states.
    typedef logic [2:0] state_t;
    localparam state_t StSettle = 3'd0;
    localparam state_t StIdle   = 3'd1;
    localparam state_t StRdData = 3'd2;
    localparam state_t StRdAddr = 3'd3;
    localparam state_t StWrHold = 3'd4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous single-bit control lines.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // No reset: the chain keeps tracking the pins during reset, so the decoder
    // sees the true strobe levels the moment reset is released.
    always_ff @(posedge clk) begin
        meta_q <= d;
        sync_q <= meta_q;
    end

    assign q = sync_q;

endmodule

// File: rtl/zxuno_regport.sv
// Z80 I/O cycle decoder for the ZX-UNO register select/data ports.
module zxuno_regport
    import zxuno_pkg::*;
#(
    parameter logic [15:0] ADDR_PORT = ZXUNO_ADDR_PORT,
    parameter logic [15:0] DATA_PORT = ZXUNO_DATA_PORT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        iorq_n,
    input  logic        m1_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic [7:0]  zxuno_addr,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic        regaddr_changed,
    output logic [7:0]  dout,
    output logic        oe_n
);

    logic [3:0] strobes_s;
    logic       iorq_s, m1_s, rd_s, wr_s;
    logic       io_s, rdq, wrq;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic       regrd_q, regrd_d;
    logic       regwr_q, regwr_d;
    logic       oe_n_q, oe_n_d;
    logic       addr_wr_q, addr_wr_d;
    logic       changed_q;

    sync2 #(
        .WIDTH(4)
    ) u_sync (
        .clk(clk),
        .d  ({iorq_n, m1_n, rd_n, wr_n}),
        .q  (strobes_s)
    );

    assign {iorq_s, m1_s, rd_s, wr_s} = strobes_s;

    // Interrupt acknowledge (IORQ with M1) is not an I/O cycle; both strobes low is no event.
    assign io_s = !iorq_s && m1_s;
    assign rdq  = io_s && !rd_s && wr_s;
    assign wrq  = io_s && !wr_s && rd_s;

    // Next-state decode: one event per I/O cycle, then hold until the strobe ends.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        regrd_d   = regrd_q;
        regwr_d   = 1'b0;
        oe_n_d    = oe_n_q;
        addr_wr_d = 1'b0;
        case (state_q)
            StSettle: begin
                // Wait out any strobe that was already active when reset dropped.
                if (!io_s && rd_s && wr_s) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (rdq && cpu_addr == DATA_PORT) begin
                    state_d = StRdData;
                    regrd_d = 1'b1;
                end else if (rdq && cpu_addr == ADDR_PORT) begin
                    state_d = StRdAddr;
                    oe_n_d  = 1'b0;
                end else if (wrq && cpu_addr == ADDR_PORT) begin
                    state_d   = StWrHold;
                    addr_d    = cpu_din;
                    addr_wr_d = 1'b1;
                end else if (wrq && cpu_addr == DATA_PORT) begin
                    state_d = StWrHold;
                    regwr_d = 1'b1;
                end
            end
            StRdData: begin
                if (!io_s || rd_s) begin
                    state_d = StIdle;
                    regrd_d = 1'b0;
                end
            end
            StRdAddr: begin
                if (!io_s || rd_s) begin
                    state_d = StIdle;
                    oe_n_d  = 1'b1;
                end
            end
            StWrHold: begin
                if (!io_s || wr_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StSettle;
                regrd_d = 1'b0;
                oe_n_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset discards any pulse still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StSettle;
            addr_q    <= 8'h00;
            regrd_q   <= 1'b0;
            regwr_q   <= 1'b0;
            oe_n_q    <= 1'b1;
            addr_wr_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            regrd_q   <= regrd_d;
            regwr_q   <= regwr_d;
            oe_n_q    <= oe_n_d;
            addr_wr_q <= addr_wr_d;
            // Delayed one cycle so consumers see the new address with the pulse.
            changed_q <= addr_wr_q;
        end
    end

    assign zxuno_addr      = addr_q;
    assign zxuno_regrd     = regrd_q;
    assign zxuno_regwr     = regwr_q;
    assign regaddr_changed = changed_q;
    assign oe_n            = oe_n_q;
    assign dout            = oe_n_q ? 8'hzz : addr_q;

endmodule

// File: tb/tb_zxuno_regport.sv
// Directed self-checking bench for the ZX-UNO register-port decoder.
module tb_zxuno_regport;
    import zxuno_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_din = 8'h00;
    logic        iorq_n = 1'b1;
    logic        m1_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic        regaddr_changed;
    logic [7:0]  dout;
    logic        oe_n;

    int checks = 0;
    int errors = 0;

    zxuno_regport dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .iorq_n         (iorq_n),
        .m1_n           (m1_n),
        .rd_n           (rd_n),
        .wr_n           (wr_n),
        .zxuno_addr     (zxuno_addr),
        .zxuno_regrd    (zxuno_regrd),
        .zxuno_regwr    (zxuno_regwr),
        .regaddr_changed(regaddr_changed),
        .dout           (dout),
        .oe_n           (oe_n)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge away from register updates.
    int         cyc = 0;
    int         regwr_cnt = 0;
    int         chg_cnt = 0;
    int         rd_rises = 0;
    int         rd_run = 0;
    int         oe_low_cnt = 0;
    int         upd_cyc = 0;
    int         chg_cyc = 0;
    logic [7:0] wr_din = 8'h00;
    logic [7:0] last_addr = 8'h00;
    logic       prev_rd = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (zxuno_addr != last_addr) upd_cyc = cyc;
        last_addr = zxuno_addr;
        if (regaddr_changed) begin
            chg_cnt = chg_cnt + 1;
            chg_cyc = cyc;
        end
        if (zxuno_regwr) begin
            regwr_cnt = regwr_cnt + 1;
            wr_din = cpu_din;
        end
        if (!oe_n) oe_low_cnt = oe_low_cnt + 1;
        if (zxuno_regrd) begin
            if (!prev_rd) begin
                rd_rises = rd_rises + 1;
                rd_run = 1;
            end else begin
                rd_run = rd_run + 1;
            end
        end
        prev_rd = zxuno_regrd;
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic io_start(input logic [15:0] addr, input logic [7:0] data, input logic m1,
                            input logic rd, input logic wr);
        @(negedge clk);
        cpu_addr = addr;
        cpu_din  = data;
        m1_n     = m1;
        iorq_n   = 1'b0;
        rd_n     = rd;
        wr_n     = wr;
    endtask

    task automatic io_end();
        @(negedge clk);
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // hold counts falling edges with the strobe low.
    task automatic io_cycle(input logic [15:0] addr, input logic [7:0] data, input logic m1,
                            input logic rd, input logic wr, input int hold);
        io_start(addr, data, m1, rd, wr);
        repeat (hold - 1) @(negedge clk);
        io_end();
    endtask

    int         w0, c0, r0, o0;
    logic [7:0] zz;

    initial begin
        zz = 8'hzz;

        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_addr", {8'h00, zxuno_addr}, 16'h0000);
        check("rst_oe_n", {15'h0, oe_n}, 16'h0001);
        check("rst_regrd", {15'h0, zxuno_regrd}, 16'h0000);
        check("rst_regwr", {15'h0, zxuno_regwr}, 16'h0000);
        check("rst_changed", {15'h0, regaddr_changed}, 16'h0000);
        check("rst_dout_z", {8'h00, dout}, {8'h00, zz});
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("settle_to_idle", {13'h0, dut.state_q}, {13'h0, StIdle});

        // Select register FF.
        w0 = regwr_cnt; c0 = chg_cnt;
        io_cycle(16'hFC3B, 8'hFF, 1'b1, 1'b1, 1'b0, 4);
        check("sel_ff_addr", {8'h00, zxuno_addr}, 16'h00FF);
        check("sel_ff_changed_cnt", 16'(chg_cnt - c0), 16'd1);
        check("sel_ff_changed_lag", 16'(chg_cyc - upd_cyc), 16'd1);
        check("sel_ff_no_regwr", 16'(regwr_cnt - w0), 16'd0);

        // Three 12-clock data reads.
        r0 = rd_rises;
        for (int i = 0; i < 3; i++) begin
            io_cycle(16'hFD3B, 8'h00, 1'b1, 1'b0, 1'b1, 12);
            check("rd_data_len", 16'(rd_run), 16'd12);
            check("rd_data_dropped", {15'h0, zxuno_regrd}, 16'h0000);
        end
        check("rd_data_periods", 16'(rd_rises - r0), 16'd3);

        // Address readback while FC3B is read.
        io_cycle(16'hFC3B, 8'h42, 1'b1, 1'b1, 1'b0, 4);
        r0 = rd_rises;
        io_start(16'hFC3B, 8'h00, 1'b1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("rd_addr_oe_n", {15'h0, oe_n}, 16'h0000);
        check("rd_addr_dout", {8'h00, dout}, 16'h0042);
        io_end();
        check("rd_addr_oe_n_after", {15'h0, oe_n}, 16'h0001);
        check("rd_addr_dout_z", {8'h00, dout}, {8'h00, zz});
        check("rd_addr_no_regrd", 16'(rd_rises - r0), 16'd0);

        // Long data write: exactly one pulse.
        w0 = regwr_cnt; c0 = chg_cnt;
        io_cycle(16'hFD3B, 8'h5A, 1'b1, 1'b1, 1'b0, 20);
        check("wr_data_pulses", 16'(regwr_cnt - w0), 16'd1);
        check("wr_data_din", {8'h00, wr_din}, 16'h005A);
        check("wr_data_addr_kept", {8'h00, zxuno_addr}, 16'h0042);
        check("wr_data_no_changed", 16'(chg_cnt - c0), 16'd0);

        // Negative cases: nothing may change.
        w0 = regwr_cnt; c0 = chg_cnt; r0 = rd_rises; o0 = oe_low_cnt;
        io_cycle(16'hFD3B, 8'h00, 1'b0, 1'b0, 1'b1, 8);
        io_cycle(16'hFD3B, 8'h77, 1'b0, 1'b1, 1'b0, 8);
        io_cycle(16'hFE3B, 8'h33, 1'b1, 1'b1, 1'b0, 8);
        io_cycle(16'hFC3B, 8'h11, 1'b1, 1'b0, 1'b0, 8);
        io_cycle(16'hFD3B, 8'h11, 1'b1, 1'b0, 1'b0, 8);
        check("neg_regwr", 16'(regwr_cnt - w0), 16'd0);
        check("neg_changed", 16'(chg_cnt - c0), 16'd0);
        check("neg_regrd", 16'(rd_rises - r0), 16'd0);
        check("neg_oe", 16'(oe_low_cnt - o0), 16'd0);
        check("neg_addr", {8'h00, zxuno_addr}, 16'h0042);

        // Reset during a data read with RD still held afterwards.
        io_start(16'hFD3B, 8'h00, 1'b1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("mid_rd_regrd_high", {15'h0, zxuno_regrd}, 16'h0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_regrd_drop", {15'h0, zxuno_regrd}, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r0 = rd_rises;
        repeat (8) @(negedge clk);
        check("held_rd_regrd", {15'h0, zxuno_regrd}, 16'h0000);
        io_end();
        check("held_rd_no_event", 16'(rd_rises - r0), 16'd0);
        check("mid_rst_addr", {8'h00, zxuno_addr}, 16'h0000);
        io_cycle(16'hFD3B, 8'h00, 1'b1, 1'b0, 1'b1, 5);
        check("post_rst_rd_event", 16'(rd_rises - r0), 16'd1);
        check("post_rst_rd_len", 16'(rd_run), 16'd5);

        // Rewriting the same address still pulses regaddr_changed.
        c0 = chg_cnt;
        io_cycle(16'hFC3B, 8'h00, 1'b1, 1'b1, 1'b0, 4);
        check("same_addr_changed", 16'(chg_cnt - c0), 16'd1);
        check("same_addr_value", {8'h00, zxuno_addr}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
